// File: rtl/hog_bank_writer.sv
// hog_bank_writer: scatters a raster pixel stream over 4 BRAM banks by (row,col) parity
module hog_bank_writer #(
  parameter int RAM_AW = 17,
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ram_busy,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              ena1,
  output logic              ena2,
  output logic              ena3,
  output logic              ena4,
  output logic              wea1,
  output logic              wea2,
  output logic              wea3,
  output logic              wea4,
  output logic [RAM_AW-1:0] AA1,
  output logic [RAM_AW-1:0] AA2,
  output logic [RAM_AW-1:0] AA3,
  output logic [RAM_AW-1:0] AA4,
  output logic [7:0]        DA1,
  output logic [7:0]        DA2,
  output logic [7:0]        DA3,
  output logic [7:0]        DA4,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  typedef enum logic [1:0] {IDLE, WAIT_RAM, RUN, DONE} state_t;
  state_t            state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [RAM_AW-1:0] row_base;
  logic [3:0]        en;
  logic [RAM_AW-1:0] aa [4];
  logic [7:0]        da [4];
  logic              accept, col_end, final_px;
  logic [1:0]        bank;
  logic [RAM_AW-1:0] addr;
  assign s_ready  = state == RUN && !ram_busy;
  assign accept   = s_valid && s_ready;
  assign col_end  = col == CW'(IMG_W - 1);
  assign final_px = col_end && row == RW'(IMG_H - 1);
  assign bank     = {row[0], col[0]};
  assign addr     = row_base + RAM_AW'(col >> 1);
  assign busy     = state != IDLE;
  assign {ena4, ena3, ena2, ena1} = en;
  assign {wea4, wea3, wea2, wea1} = en;
  assign AA1 = aa[0];
  assign AA2 = aa[1];
  assign AA3 = aa[2];
  assign AA4 = aa[3];
  assign DA1 = da[0];
  assign DA2 = da[1];
  assign DA3 = da[2];
  assign DA4 = da[3];
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      row_base   <= '0;
      en         <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        aa[i] <= '0;
        da[i] <= '0;
      end
    end else begin
      frame_done <= state == DONE;
      en         <= accept ? 4'b0001 << bank : 4'b0000;
      for (int i = 0; i < 4; i++)
        if (accept && bank == 2'(i)) begin
          aa[i] <= addr;
          da[i] <= s_data;
        end
      case (state)
        IDLE:
          if (start) begin
            state     <= WAIT_RAM;
            col       <= '0;
            row       <= '0;
            row_base  <= '0;
            frame_err <= 1'b0;
          end
        WAIT_RAM: if (!ram_busy) state <= RUN;
        RUN:
          if (accept) begin
            if (s_last != final_px) frame_err <= 1'b1;
            col <= col_end ? '0 : col + 1'b1;
            // each bank row spans two image rows, so the base steps after odd rows
            if (col_end) begin
              row <= row + 1'b1;
              if (row[0]) row_base <= row_base + RAM_AW'(IMG_W / 2);
            end
            if (final_px) state <= DONE;
          end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule
